// File: rtl/eth_tx_framer.sv
// Ethernet MAC transmit framer: preamble/SFD insertion, inline CRC-32 FCS, inter-frame gap.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_DATA_LEN bytes before the FCS.
module eth_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_DATA_LEN = 60,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       tx_busy
);

`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg} state_e;
  localparam bit PadEn = 1'b1;
  // A short frame continues into padding only when padding is built in.
  localparam state_e StShort = StPad;
`else
  typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StFcs, StIfg} state_e;
  localparam bit PadEn = 1'b0;
  localparam state_e StShort = StFcs;
`endif

  state_e      state_q;
  logic [31:0] crc_q;
  logic [31:0] crc_data;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic [15:0] byte_cnt_q;
  logic [15:0] byte_cnt_inc;
  logic [16:0] cnt_inc;
  logic [3:0]  pre_cnt_q;
  logic [15:0] ifg_cnt_q;
  logic [1:0]  fcs_idx_q;
  logic        need_pad;
`ifdef ETH_TX_PAD_EN
  logic [31:0] crc_pad;
`endif

  // MSB-first CRC-32 register fed with data bits LSB first, one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    crc_data     = crc_byte(crc_q, s_data);
    cnt_inc      = {1'b0, byte_cnt_q} + 17'd1;
    byte_cnt_inc = cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];
    need_pad     = PadEn && (cnt_inc < 17'(MIN_DATA_LEN));
    for (int i = 0; i < 32; i++) begin
      fcs_word[i] = ~crc_q[31-i];
    end
    fcs_byte = fcs_word[{fcs_idx_q, 3'b000} +: 8];
  end

`ifdef ETH_TX_PAD_EN
  always_comb begin
    crc_pad = crc_byte(crc_q, 8'h00);
  end
`endif

  assign s_ready = (state_q == StData);
  assign tx_busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      txd        <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      crc_q      <= 32'hFFFF_FFFF;
      byte_cnt_q <= 16'd0;
      pre_cnt_q  <= 4'd0;
      ifg_cnt_q  <= 16'd0;
      fcs_idx_q  <= 2'd0;
    end else begin
      tx_er <= 1'b0;
      unique case (state_q)
        StIdle: begin
          txd       <= 8'h00;
          tx_en     <= 1'b0;
          pre_cnt_q <= 4'd0;
          if (s_valid) state_q <= StPre;
        end
        StPre: begin
          txd   <= 8'h55;
          tx_en <= 1'b1;
          if (pre_cnt_q == 4'(PREAMBLE_LEN - 1)) state_q <= StSfd;
          else                                   pre_cnt_q <= pre_cnt_q + 4'd1;
        end
        StSfd: begin
          txd        <= 8'hD5;
          tx_en      <= 1'b1;
          crc_q      <= 32'hFFFF_FFFF;
          byte_cnt_q <= 16'd0;
          fcs_idx_q  <= 2'd0;
          ifg_cnt_q  <= 16'd0;
          state_q    <= StData;
        end
        StData: begin
          tx_en <= 1'b1;
          if (s_valid) begin
            txd        <= s_data;
            crc_q      <= crc_data;
            byte_cnt_q <= byte_cnt_inc;
            if (s_last) state_q <= need_pad ? StShort : StFcs;
          end else begin
            // Underrun: mark the frame bad and abandon it without an FCS.
            txd     <= 8'h00;
            tx_er   <= 1'b1;
            state_q <= StIfg;
          end
        end
`ifdef ETH_TX_PAD_EN
        StPad: begin
          txd        <= 8'h00;
          tx_en      <= 1'b1;
          crc_q      <= crc_pad;
          byte_cnt_q <= byte_cnt_inc;
          if (!need_pad) state_q <= StFcs;
        end
`endif
        StFcs: begin
          txd   <= fcs_byte;
          tx_en <= 1'b1;
          if (fcs_idx_q == 2'd3) state_q <= StIfg;
          else                   fcs_idx_q <= fcs_idx_q + 2'd1;
        end
        StIfg: begin
          txd   <= 8'h00;
          tx_en <= 1'b0;
          if (ifg_cnt_q == 16'(IFG_LEN - 1)) state_q <= StIdle;
          else                               ifg_cnt_q <= ifg_cnt_q + 16'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: random frames against a byte-level frame model.
// Follows ETH_TX_PAD_EN in its expectations, so it works for either build.
module tb_eth_tx_framer;
  typedef logic [7:0] u8_t;
  typedef u8_t q8_t[$];

  localparam int unsigned PreLen = 7;
  localparam int unsigned MinLen = 60;
  localparam int unsigned IfgLen = 12;
`ifdef ETH_TX_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_tx_framer #(
    .PREAMBLE_LEN(PreLen),
    .MIN_DATA_LEN(MinLen),
    .IFG_LEN     (IfgLen)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .txd    (txd),
    .tx_en  (tx_en),
    .tx_er  (tx_er),
    .tx_busy(tx_busy)
  );

  // Line monitor: collects every byte sent while tx_en is high and measures idle gaps.
  q8_t cap_q;
  bit  er_q[$];
  int  gaps[$];
  int  gap_cnt = 0;
  bit  prev_en = 1'b0;
  bit  seen_fall = 1'b0;

  always @(posedge clk) begin
    #1;
    if (tx_en === 1'b1) begin
      if (!prev_en && seen_fall) gaps.push_back(gap_cnt);
      cap_q.push_back(txd);
      er_q.push_back(tx_er);
    end else begin
      if (prev_en) begin
        seen_fall = 1'b1;
        gap_cnt   = 0;
      end
      gap_cnt++;
    end
    prev_en = (tx_en === 1'b1);
  end

  task automatic clear_mon();
    cap_q.delete();
    er_q.delete();
    gaps.delete();
    seen_fall = 1'b0;
    gap_cnt   = 0;
  endtask

  // Reference CRC-32 (reflected form, IEEE 802.3) of a byte string.
  function automatic logic [31:0] crc32_sw(q8_t d);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected line bytes for one complete frame.
  function automatic q8_t build_exp(q8_t d);
    q8_t body, e;
    logic [31:0] fcs;
    body = d;
    if (PadEn) while (body.size() < MinLen) body.push_back(8'h00);
    fcs = crc32_sw(body);
    repeat (PreLen) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (body[i]) e.push_back(body[i]);
    for (int k = 0; k < 4; k++) e.push_back(fcs[8*k +: 8]);
    return e;
  endfunction

  function automatic int first_diff(q8_t a, q8_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic u8_t peek(q8_t a, int i);
    if (i >= 0 && i < a.size()) return a[i];
    return 8'hxx;
  endfunction

  function automatic int count_er();
    int n;
    n = 0;
    foreach (er_q[i]) if (er_q[i]) n++;
    return n;
  endfunction

  function automatic q8_t rand_bytes(int n);
    q8_t d;
    for (int i = 0; i < n; i++) d.push_back(u8_t'($urandom_range(0, 255)));
    return d;
  endfunction

  // Streams one frame; drop_at >= 0 withholds s_valid for one DATA cycle at that byte.
  task automatic send_frame(input q8_t d, input int drop_at, input bit hold_after);
    int  idx;
    int  guard;
    bit  rdy;
    bit  dropped;
    idx = 0;
    guard = 0;
    dropped = 1'b0;
    while (idx < d.size()) begin
      @(negedge clk);
      rdy     = s_ready;
      s_data  = d[idx];
      s_last  = (idx == d.size() - 1);
      s_valid = 1'b1;
      if (idx == drop_at && rdy) begin
        s_valid = 1'b0;
        dropped = 1'b1;
      end
      @(posedge clk);
      if (dropped) break;
      if (rdy) idx++;
      guard++;
      if (guard > 200000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, d.size());
        break;
      end
    end
    if (!hold_after) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Waits for IDLE; counts cycles in which s_ready was seen high meanwhile.
  task automatic wait_idle(output int rdy_hi);
    bit done;
    rdy_hi = 0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (s_ready) rdy_hi++;
      if (!tx_busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: tx_busy %0b, required 0", tx_busy);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    #2;
    checks++; if (txd !== 8'h00) begin errors++; $display("FAIL reset_txd: %02h vs 00", txd); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: %b vs 0", tx_en); end
    checks++; if (tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: %b vs 0", tx_er); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b vs 0", tx_busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: %b vs 0", s_ready); end
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = 8'hA5;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL mid_frame_en: %b vs 1", tx_en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL abort_tx_en: %b vs 0", tx_en); end
    checks++; if (tx_er !== 1'b0) begin errors++; $display("FAIL abort_tx_er: %b vs 0", tx_er); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: %b vs 0", tx_busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: %b vs 0", s_ready); end
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_crc_vector();
    q8_t d, e;
    int  rh, mis;
    logic [31:0] fcs;
    for (int i = 0; i < 9; i++) d.push_back(u8_t'(8'h31 + i));
    e = build_exp(d);
    clear_mon();
    send_frame(d, -1, 1'b0);
    wait_idle(rh);
    mis = first_diff(cap_q, e);
    checks++;
    if (mis != -1) begin
      errors++;
      $display("FAIL crc_vector: byte %0d got %02h expected %02h, len %0d expected %0d",
               mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size());
    end
    if (!PadEn) begin
      fcs = {peek(cap_q, 20), peek(cap_q, 19), peek(cap_q, 18), peek(cap_q, 17)};
      checks++;
      if (fcs !== 32'hCBF4_3926) begin
        errors++;
        $display("FAIL crc_vector_fcs: %08h vs CBF43926", fcs);
      end
    end
    checks++;
    if (gap_cnt != IfgLen) begin
      errors++;
      $display("FAIL ifg_len: low cycles %0d, required %0d", gap_cnt, IfgLen);
    end
    checks++;
    if (count_er() != 0) begin errors++; $display("FAIL crc_vector_er: %0d vs 0", count_er()); end
  endtask

  task automatic test_pad();
    q8_t d, e;
    int  rh, mis;
    d = rand_bytes(14);
    e = build_exp(d);
    clear_mon();
    send_frame(d, -1, 1'b0);
    wait_idle(rh);
    mis = first_diff(cap_q, e);
    checks++;
    if (mis != -1) begin
      errors++;
      $display("FAIL pad_frame: byte %0d got %02h expected %02h, len %0d expected %0d",
               mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size());
    end
  endtask

  task automatic test_min_len();
    q8_t d, e;
    int  rh, mis;
    foreach (d[i]) d.delete(i);
    d = rand_bytes(MinLen);
    e = build_exp(d);
    clear_mon();
    send_frame(d, -1, 1'b0);
    wait_idle(rh);
    mis = first_diff(cap_q, e);
    checks++;
    if (mis != -1) begin
      errors++;
      $display("FAIL min_len_frame: byte %0d got %02h expected %02h, len %0d expected %0d",
               mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size());
    end
  endtask

  task automatic test_underrun();
    q8_t d, e;
    int  rh, mis, er_pos;
    d = rand_bytes(40);
    repeat (PreLen) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int i = 0; i < 20; i++) e.push_back(d[i]);
    e.push_back(8'h00);
    er_pos = PreLen + 1 + 20;
    clear_mon();
    send_frame(d, 20, 1'b0);
    wait_idle(rh);
    mis = first_diff(cap_q, e);
    checks++;
    if (mis != -1) begin
      errors++;
      $display("FAIL underrun_frame: byte %0d got %02h expected %02h, len %0d expected %0d",
               mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size());
    end
    checks++;
    if (count_er() != 1 || er_q.size() <= er_pos || !er_q[er_pos]) begin
      errors++;
      $display("FAIL underrun_er: %0d error bytes, required 1 at byte %0d", count_er(), er_pos);
    end
    checks++;
    if (rh != 0) begin errors++; $display("FAIL underrun_ready: high %0d cycles vs 0", rh); end
  endtask

  task automatic test_back_to_back();
    q8_t d1, d2, e;
    int  rh, mis, g;
    d1 = rand_bytes(64);
    d2 = rand_bytes(64);
    e = {build_exp(d1), build_exp(d2)};
    clear_mon();
    send_frame(d1, -1, 1'b1);
    send_frame(d2, -1, 1'b0);
    wait_idle(rh);
    mis = first_diff(cap_q, e);
    checks++;
    if (mis != -1) begin
      errors++;
      $display("FAIL back_to_back: byte %0d got %02h expected %02h, len %0d expected %0d",
               mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size());
    end
    g = (gaps.size() > 0) ? gaps[0] : -1;
    checks++;
    if (gaps.size() != 1 || g != int'(IfgLen + 1)) begin
      errors++;
      $display("FAIL back_to_back_gap: %0d gaps first %0d, required 1 gap of %0d",
               gaps.size(), g, IfgLen + 1);
    end
  endtask

  task automatic test_random_frames();
    q8_t d, e;
    int  rh, mis;
    for (int k = 0; k < 8; k++) begin
      d = rand_bytes(int'($urandom_range(1, 90)));
      e = build_exp(d);
      clear_mon();
      send_frame(d, -1, 1'b0);
      wait_idle(rh);
      mis = first_diff(cap_q, e);
      checks++;
      if (mis != -1 || count_er() != 0) begin
        errors++;
        $display("FAIL random_frame_%0d: byte %0d got %02h expected %02h, len %0d expected %0d, er %0d",
                 k, mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size(), count_er());
      end
    end
  endtask

  task automatic test_long_frame();
    q8_t d, e;
    int  rh, mis;
    d = rand_bytes(65540);
    e = build_exp(d);
    clear_mon();
    send_frame(d, -1, 1'b0);
    wait_idle(rh);
    mis = first_diff(cap_q, e);
    checks++;
    if (mis != -1) begin
      errors++;
      $display("FAIL long_frame: byte %0d got %02h expected %02h, len %0d expected %0d",
               mis, peek(cap_q, mis), peek(e, mis), cap_q.size(), e.size());
    end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_pad();
    test_min_len();
    test_underrun();
    test_back_to_back();
    test_random_frames();
    test_long_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
